// File: rtl/list_fetch_pkg.sv
// Shared types and constants for the list fetcher: FSM states, default widths
// and the byte offsets of the list regions inside the node memory.
package list_fetch_pkg;

  localparam int ADDR_W_DEF    = 11;
  localparam int WORD_W_DEF    = 16;
  localparam int MAX_COUNT_DEF = 64;
  localparam int IDX_W         = 6;

  // Node-memory region byte addresses (11-bit address space)
  localparam logic [10:0] KNOWN_SINKS      = 11'h008;
  localparam logic [10:0] NEIGHBOR_ID      = 11'h048;
  localparam logic [10:0] KNOWN_SINK_COUNT = 11'h688;
  localparam logic [10:0] NEIGHBOR_COUNT   = 11'h68A;
  localparam logic [10:0] SINK_ID_COUNT    = 11'h68E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT,
    ST_FETCH,
    ST_HOLD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/list_fetch_if.sv
// Bundle of the request, memory read port and entry stream of list_fetch.
// Entry stream: an entry transfers on a rising edge where out_valid and
// out_ready are both high; while out_valid=1 and out_ready=0 the entry is held.
interface list_fetch_if
  import list_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) ();

  logic              start;
  logic [ADDR_W-1:0] count_addr;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;
  logic [WORD_W-1:0] out_data;
  logic [IDX_W-1:0]  out_index;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              err_clamp;

  modport slave (
    input  start, count_addr, base_addr, mem_rdata, out_ready,
    output mem_addr, out_data, out_index, out_valid, busy, done, err_clamp
  );

  modport master (
    output start, count_addr, base_addr, mem_rdata, out_ready,
    input  mem_addr, out_data, out_index, out_valid, busy, done, err_clamp
  );

endinterface

// File: rtl/list_fetch.sv
// Reads a count word, then streams up to MAX_COUNT consecutive 16-bit list
// entries from the node memory to a valid/ready consumer.
module list_fetch
  import list_fetch_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int WORD_W    = WORD_W_DEF,
  parameter int MAX_COUNT = MAX_COUNT_DEF
) (
  input  logic   clock,
  input  logic   reset,
  list_fetch_if.slave bus,
  output state_t state
);

  localparam int                CNT_W    = $clog2(MAX_COUNT + 1);
  localparam logic [WORD_W-1:0] MAX_WORD = WORD_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_COUNT);

  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  count;
  logic              last;

  assign last = (CNT_W'(bus.out_index) == (count - CNT_W'(1)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      base          <= '0;
      count         <= '0;
      bus.mem_addr  <= '0;
      bus.out_data  <= '0;
      bus.out_index <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err_clamp <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            bus.mem_addr  <= bus.count_addr;
            base          <= bus.base_addr;
            bus.err_clamp <= 1'b0;
            bus.busy      <= 1'b1;
            state         <= ST_CNT;
          end
        end
        ST_CNT: begin
          if (bus.mem_rdata > MAX_WORD) begin
            count         <= MAX_CNT;
            bus.err_clamp <= 1'b1;
          end else begin
            count <= CNT_W'(bus.mem_rdata);
          end
          // Decide on the raw word: count itself only updates on this edge
          if (bus.mem_rdata == '0) begin
            bus.done <= 1'b1;
            state    <= ST_DONE;
          end else begin
            bus.mem_addr  <= base;
            bus.out_index <= '0;
            state         <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          bus.out_data  <= bus.mem_rdata;
          bus.out_valid <= 1'b1;
          state         <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (last) begin
              bus.done <= 1'b1;
              state    <= ST_DONE;
            end else begin
              bus.out_index <= bus.out_index + IDX_W'(1);
              bus.mem_addr  <= bus.mem_addr + ADDR_W'(2);
              state         <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/list_fetch.md
LIST_FETCH -- requirements
Module: list_fetch

Interface
REQ-001 Parameter ADDR_W, default 11: byte-address width of the node memory.
REQ-002 Parameter WORD_W, default 16: data word width (two big-endian bytes).
REQ-003 Parameter MAX_COUNT, default 64: largest number of list entries fetched.
REQ-004 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port start, input, 1: request a list fetch; sampled only in IDLE.
REQ-007 Port count_addr, input, ADDR_W: byte address of the list's count word; sampled with start.
REQ-008 Port base_addr, input, ADDR_W: byte address of list entry 0; sampled with start.
REQ-009 Port mem_addr, output, ADDR_W: registered address driven to the memory read port.
REQ-010 Port mem_rdata, input, WORD_W: combinational memory read data for mem_addr.
REQ-011 Port out_data, output, WORD_W: current list entry.
REQ-012 Port out_index, output, 6: index of the current entry.
REQ-013 Port out_valid, output, 1: out_data and out_index are valid.
REQ-014 Port out_ready, input, 1: the consumer accepts the entry when out_valid and out_ready are both high.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port done, output, 1: one-cycle pulse at the end of a fetch.
REQ-017 Port err_clamp, output, 1: count word exceeded MAX_COUNT; held until the next accepted start.

Function
REQ-018 States SHALL be IDLE, CNT, FETCH, HOLD and DONE; the reset state SHALL be IDLE.
REQ-019 In IDLE, start=1 SHALL register mem_addr<=count_addr, base<=base_addr and err_clamp<=0, then go to CNT.
REQ-020 In CNT, the block SHALL latch count<=min(mem_rdata, MAX_COUNT) and set err_clamp when mem_rdata>MAX_COUNT (unsigned compare).
REQ-021 In CNT, count==0 SHALL go to DONE; otherwise it SHALL set mem_addr<=base, index<=0 and go to FETCH.
REQ-022 In FETCH, the block SHALL register out_data<=mem_rdata and out_valid<=1, then go to HOLD.
REQ-023 In HOLD, out_data and out_index SHALL stay stable while out_ready=0.
REQ-024 In HOLD, a handshake SHALL clear out_valid.
REQ-025 On that handshake, index==count-1 SHALL go to DONE; otherwise index+=1, mem_addr+=2 (modulo 2^ADDR_W) and go to FETCH.
REQ-026 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-027 start asserted in any state other than IDLE SHALL be ignored.
REQ-028 Timing: the first out_valid SHALL rise 3 cycles after start is sampled; each later entry SHALL follow at least 2 cycles after the previous handshake.
REQ-029 Address arithmetic SHALL wrap silently; odd addresses SHALL be used as given.
REQ-030 mem_addr SHALL change only on clock edges, never combinationally.

Reset
REQ-031 Asserting reset SHALL immediately force state=IDLE, all outputs to 0, count=0 and index=0.
REQ-032 Reset in mid-fetch SHALL abort the fetch with no done pulse.
REQ-033 Fetching SHALL resume only on a new start after reset is released.

Structure
REQ-034 Package list_fetch_pkg SHALL hold the state enum, the ADDR_W/WORD_W defaults and the node-memory region constants.
REQ-035 The region constants SHALL be: knownSinks 0x008, neighborID 0x048, knownSinkCount 0x688, neighborCount 0x68A, sinkIDCount 0x68E.
REQ-036 The block SHALL have no sub-module; the bench SHALL connect it to the existing node memory with write enable tied low.

Verification
REQ-037 Known-sink list: count 0x688=5, base 0x008, out_ready=1 -> out_data 2,5,10,171,205 with indices 0..4; then one done pulse; err_clamp=0.
REQ-038 Empty list: count word=0 -> no out_valid; done 2 cycles after start is sampled; busy low afterwards.
REQ-039 Clamp: count word=100 with MAX_COUNT=64 -> err_clamp=1; exactly 64 entries, last out_index=63.
REQ-040 Backpressure: out_ready low for 3 cycles on entry 2 -> out_data/out_index held constant; no entry lost or duplicated.
REQ-041 Wrap: base 0x7FE with count 2 -> mem_addr reads 0x7FE then 0x000.
REQ-042 Reset mid-list after entry 1 -> outputs 0 immediately; no done; a new start refetches from index 0.
